// File: rtl/bit_serial_neuron.sv
// Bit-serial weighted-sum neuron.
// Each of N_IN streams delivers an unsigned operand LSB first, one bit per
// clock. The block accumulates the signed weighted sum over WIDTH cycles,
// thresholds it, and pulses done for one cycle with the registered result.
module bit_serial_neuron #(
  parameter int N_IN  = 4,
  parameter int WIDTH = 8,
  parameter int ACC_W = 19,
  parameter logic signed [ACC_W-1:0] THRESH = '0
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    start,
  input  logic [N_IN-1:0]         x_bit,
  input  logic [N_IN*WIDTH-1:0]   w,
  output logic                    busy,
  output logic                    done,
  output logic [ACC_W-1:0]        acc_out,
  output logic                    y
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t                   state, state_nxt;
  logic [CW-1:0]            cnt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  partial;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic [WIDTH-1:0]         w_reg [N_IN];
  logic                     accept;

  // A start is honoured only from IDLE or DONE; in ACCUM it is dropped.
  assign accept = start && ((state == IDLE) || (state == DONE));

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!clr) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = start ? ACCUM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded directly from the state.
  always_comb begin
    busy = (state == ACCUM);
    done = (state == DONE);
  end

  // Sum of sign-extended captured weights for the streams whose bit is set.
  always_comb begin
    partial = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (x_bit[i])
        partial = partial + {{(ACC_W-WIDTH){w_reg[i][WIDTH-1]}}, w_reg[i]};
    end
  end

  assign acc_nxt = acc + (partial << cnt);

  // Datapath: weight capture, shift-and-add accumulation, result register.
  // The final bit's contribution is folded in combinationally so acc_out and
  // y are valid on the same edge that enters DONE.
  always_ff @(posedge clk) begin
    if (!clr) begin
      acc     <= '0;
      cnt     <= '0;
      acc_out <= '0;
      y       <= 1'b0;
      for (int unsigned i = 0; i < N_IN; i++) w_reg[i] <= '0;
    end else if (accept) begin
      for (int unsigned i = 0; i < N_IN; i++) w_reg[i] <= w[i*WIDTH +: WIDTH];
      acc <= '0;
      cnt <= '0;
    end else if (state == ACCUM) begin
      acc <= acc_nxt;
      cnt <= cnt + CW'(1);
      if (cnt == LAST) begin
        acc_out <= acc_nxt;
        y       <= (acc_nxt >= THRESH);
      end
    end
  end

endmodule
